wb_ram_bridge: RTL
==================

WB_RAM_BRIDGE -- requirements
Module: wb_ram_bridge

Interface
REQ-001 SHALL have parameter WORDS, default 256, the RAM depth in 32-bit words (power of two).
REQ-002 SHALL have parameter BASE, default 32'h1000_0000, the byte base address, aligned to WORDS*4.
REQ-003 SHALL have clock `ck` (input, 1), the single clock; all logic is on the rising edge.
REQ-004 SHALL have reset `rst_n` (input, 1), asynchronous, active-low.
REQ-005 SHALL have `wb_cyc` (input, 1), bus cycle valid.
REQ-006 SHALL have `wb_stb` (input, 1), strobe.
REQ-007 SHALL have `wb_we` (input, 1), 1 = write.
REQ-008 SHALL have `wb_sel` (input, 4), byte lane enables.
REQ-009 SHALL have `wb_adr` (input, 32), byte address.
REQ-010 SHALL have `wb_dat_w` (input, 32), write data.
REQ-011 SHALL have `wb_dat_r` (output, 32), read data.
REQ-012 SHALL have `wb_ack` (output, 1), transfer done.
REQ-013 SHALL have `wb_err` (output, 1), address error.
REQ-014 SHALL have RAM-side outputs `ram_cyc` (1), `ram_we` (1), `ram_sel` (4), `ram_addr` (32, word index) and `ram_wdata` (32); all are registered.
REQ-015 SHALL have RAM-side input `ram_rdata` (32), valid the cycle after a RAM read cycle (1-cycle latency).

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, ACK and ERR, with one state per clock.
REQ-017 IDLE: SHALL accept a request when wb_cyc&wb_stb; an in-range request goes to ISSUE, an out-of-range request goes to ERR.
REQ-018 In range SHALL mean BASE <= wb_adr < BASE+4*WORDS; wb_adr[1:0] SHALL be ignored (word-aligned access).
REQ-019 On accept, SHALL register ram_addr = (wb_adr-BASE)>>2, zero-extended to 32 bits, and also register ram_we=wb_we, ram_sel=wb_sel and ram_wdata=wb_dat_w.
REQ-020 ISSUE: ram_cyc SHALL be 1 for exactly this one cycle; next state is ACK if write, WAIT if read.
REQ-021 WAIT: SHALL capture ram_rdata (full 32 bits, wb_sel ignored on reads) into wb_dat_r; next state is ACK.
REQ-022 ACK: wb_ack SHALL be 1 for exactly this cycle, then the FSM returns to IDLE.
REQ-023 ERR: wb_err SHALL be 1 for exactly this cycle, then the FSM returns to IDLE; ram_cyc SHALL never assert for an out-of-range request.
REQ-024 Latency, counted from the accept edge: write ack on cycle +2, read ack on cycle +3, err on cycle +1.
REQ-025 wb_ack and wb_err SHALL never be 1 simultaneously, and neither SHALL be 1 while wb_cyc=0.
REQ-026 No new request SHALL be accepted in any state other than IDLE; a request held through the ACK or ERR cycle SHALL NOT be re-accepted in that cycle.
REQ-027 Abort: if wb_cyc=0 in WAIT, ACK or ERR, SHALL go to IDLE with no ack or err.
REQ-028 Abort during ISSUE: the RAM cycle SHALL still complete (write committed), and the FSM SHALL follow REQ-027 from the next state.
REQ-029 wb_dat_r SHALL hold its value until the next WAIT capture.
REQ-030 ram_we, ram_sel and ram_wdata SHALL hold their values outside ISSUE; only ram_cyc qualifies them.

Reset
REQ-031 On rst_n=0, immediately and regardless of the clock: state SHALL be IDLE; wb_ack, wb_err, wb_dat_r, ram_cyc, ram_we, ram_sel, ram_addr and ram_wdata SHALL all be 0.
REQ-032 Reset mid-transaction SHALL drop any pending ack or err; a RAM write in ISSUE at the time of reset is not guaranteed to commit.
REQ-033 The first request SHALL be accepted on the first rising edge with rst_n=1.

Verification (BASE=32'h1000_0000, WORDS=256, bridge driving sp_ram)
REQ-034 Write, adr 32'h1000_0010, data 32'hDEAD_BEEF, sel 4'hF -> one-cycle ram_cyc=1 with ram_we=1 and ram_addr=4; wb_ack at +2.
REQ-035 Read, adr 32'h1000_0010 -> ram_cyc=1 with ram_we=0; wb_dat_r=32'hDEAD_BEEF with wb_ack at +3.
REQ-036 Write, adr 32'h1000_0010, sel 4'b0010, data 32'h0000_AA00, then read back -> 32'hDEAD_AAEF.
REQ-037 Access adr 32'h1000_0400, and separately adr 32'h0FFF_FFFC -> wb_err at +1 for each; ram_cyc stays 0; wb_ack stays 0.
REQ-038 Read, drop wb_cyc during WAIT -> no wb_ack; FSM is in IDLE next cycle; the following write of 32'h1234_5678 to adr 32'h1000_0000 acks at +2.
REQ-039 rst_n=0 asserted mid-ISSUE between clock edges -> ram_cyc and state clear without waiting for an edge; no ack follows; wb_dat_r=0.

Source files
------------

// File: rtl/wb_ram_bridge.sv
// Wishbone classic slave bridging onto a 1-cycle-latency single-port RAM.
// Write ack +2, read ack +3, range error +1 from accept; one transfer at a time.
module wb_ram_bridge #(
  parameter int unsigned WORDS = 256,
  parameter logic [31:0] BASE  = 32'h1000_0000
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_w,
  output logic [31:0] wb_dat_r,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        ram_cyc,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK, S_ERR} state_t;

  localparam logic [32:0] SPAN = 33'(WORDS) << 2;

  state_t      r_state;
  state_t      w_next;
  logic        r_ram_cyc;
  logic        r_ram_we;
  logic [3:0]  r_ram_sel;
  logic [31:0] r_ram_addr;
  logic [31:0] r_ram_wdata;
  logic [31:0] r_dat_r;
  logic [31:0] w_off;
  logic        w_in_range;
  logic        w_req;

  // Subtracting BASE turns below-base addresses into huge offsets, so one compare covers both bounds.
  assign w_off      = wb_adr - BASE;
  assign w_in_range = ({1'b0, w_off} < SPAN);
  assign w_req      = wb_cyc & wb_stb;

  always_comb begin
    w_next = r_state;
    wb_ack = 1'b0;
    wb_err = 1'b0;
    case (r_state)
      S_IDLE:  if (w_req) w_next = w_in_range ? S_ISSUE : S_ERR;
      S_ISSUE: w_next = r_ram_we ? S_ACK : S_WAIT;
      S_WAIT:  w_next = wb_cyc ? S_ACK : S_IDLE;
      S_ACK: begin
        wb_ack = wb_cyc;
        w_next = S_IDLE;
      end
      S_ERR: begin
        wb_err = wb_cyc;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ram_cyc   <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_sel   <= 4'h0;
      r_ram_addr  <= 32'h0;
      r_ram_wdata <= 32'h0;
      r_dat_r     <= 32'h0;
    end else begin
      r_state   <= w_next;
      r_ram_cyc <= (w_next == S_ISSUE);
      if (r_state == S_IDLE && w_req) begin
        r_ram_we    <= wb_we;
        r_ram_sel   <= wb_sel;
        r_ram_addr  <= {2'b00, w_off[31:2]};
        r_ram_wdata <= wb_dat_w;
      end
      if (r_state == S_WAIT) r_dat_r <= ram_rdata;
    end
  end

  assign ram_cyc   = r_ram_cyc;
  assign ram_we    = r_ram_we;
  assign ram_sel   = r_ram_sel;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign wb_dat_r  = r_dat_r;

endmodule
